// File: rtl/hline_setup.sv
// hline_setup: orders span endpoints, divides depth delta by pixel count, computes buffer addresses, launches span fill
module hline_setup (
   input  logic        clk,
   input  logic        nreset,
   input  logic        start,
   input  logic [15:0] x1,
   input  logic [15:0] x2,
   input  logic [15:0] y,
   input  logic [31:0] z1,
   input  logic [31:0] z2,
   input  logic [31:0] fb_base,
   input  logic [31:0] zb_base,
   input  logic [15:0] stride,
   input  logic        hl_done,
   output logic        hl_start,
   output logic [31:0] dx,
   output logic [31:0] slope,
   output logic [31:0] rem,
   output logic [31:0] err,
   output logic [31:0] z_start,
   output logic [31:0] fb_addr,
   output logic [31:0] zbuff_addr,
   output logic        busy,
   output logic        done
);
   typedef enum logic [2:0] {IDLE, ORDER, DIV, ADDR, ISSUE, WAIT, DONE} state_t;
   state_t      state_q;
   logic [15:0] x1_q, x2_q, y_q, stride_q, xl_q, rem_q, xl_d, xr, rem_d;
   logic [31:0] z1_q, z2_q, fbb_q, zbb_q, zl_q, quo_q, zl_d, zr, mag_d, quo_d, pix, slope_d;
   logic [16:0] dxc_q, dx_d, trial;
   logic [32:0] dz;
   logic [4:0]  cnt_q;
   logic        neg_q, first_q, swap, ge;
   // endpoint ordering, one restoring-divide step (quo_q shifts dividend out and quotient in), address math
   always_comb begin
      swap    = x1_q > x2_q;
      xl_d    = swap ? x2_q : x1_q;
      xr      = swap ? x1_q : x2_q;
      zl_d    = swap ? z2_q : z1_q;
      zr      = swap ? z1_q : z2_q;
      dx_d    = {1'b0, xr} - {1'b0, xl_d} + 17'd1;
      dz      = {1'b0, zr} - {1'b0, zl_d};
      mag_d   = dz[32] ? -dz[31:0] : dz[31:0];
      trial   = {rem_q, quo_q[31]};
      ge      = trial >= dxc_q;
      rem_d   = ge ? 16'(trial - dxc_q) : trial[15:0];
      quo_d   = {quo_q[30:0], ge};
      pix     = {16'b0, y_q} * {16'b0, stride_q} + {16'b0, xl_q};
      slope_d = neg_q ? -quo_q : quo_q;
   end
   // span sequencer with registered handshake and result outputs
   always_ff @(posedge clk) begin
      if (!nreset) begin
         state_q    <= IDLE;
         {x1_q, x2_q, y_q, stride_q, xl_q, rem_q} <= '0;
         {z1_q, z2_q, fbb_q, zbb_q, zl_q, quo_q}  <= '0;
         dxc_q      <= '0;
         cnt_q      <= '0;
         neg_q      <= 1'b0;
         first_q    <= 1'b0;
         hl_start   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         {dx, slope, rem, err, z_start, fb_addr, zbuff_addr} <= '0;
      end else begin
         hl_start <= 1'b0;
         done     <= 1'b0;
         case (state_q)
            IDLE: if (start) begin
               {x1_q, x2_q, y_q, stride_q} <= {x1, x2, y, stride};
               {z1_q, z2_q, fbb_q, zbb_q}  <= {z1, z2, fb_base, zb_base};
               busy    <= 1'b1;
               state_q <= ORDER;
            end
            ORDER: begin
               xl_q    <= xl_d;
               zl_q    <= zl_d;
               dxc_q   <= dx_d;
               neg_q   <= dz[32];
               quo_q   <= mag_d;
               rem_q   <= '0;
               cnt_q   <= '0;
               state_q <= DIV;
            end
            DIV: begin
               quo_q   <= quo_d;
               rem_q   <= rem_d;
               cnt_q   <= cnt_q + 5'd1;
               state_q <= cnt_q == 5'd31 ? ADDR : DIV;
            end
            ADDR: begin
               dx         <= {15'b0, dxc_q};
               slope      <= slope_d;
               rem        <= {16'b0, rem_q};
               err        <= '0;
               z_start    <= zl_q;
               fb_addr    <= fbb_q + (pix << 2);
               zbuff_addr <= zbb_q + (pix << 2);
               hl_start   <= 1'b1;
               state_q    <= ISSUE;
            end
            ISSUE: begin
               first_q <= 1'b1;
               state_q <= WAIT;
            end
            WAIT: begin
               first_q <= 1'b0;
               if (!first_q && hl_done) begin
                  done    <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               busy    <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy    <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_hline_setup.sv
// tb_hline_setup: randomized and directed checks of hline_setup against an arithmetic span model
module tb_hline_setup;
  logic        clk = 1'b0, nreset, start, hl_done;
  logic [15:0] x1, x2, y, stride;
  logic [31:0] z1, z2, fb_base, zb_base;
  logic        hl_start, busy, done;
  logic [31:0] dx, slope, rem, err, z_start, fb_addr, zbuff_addr;
  int          errs = 0, checks = 0;
  string       fn[7] = '{"dx", "slope", "rem", "err", "z_start", "fb_addr", "zbuff_addr"};
  hline_setup dut (
    .clk(clk), .nreset(nreset), .start(start), .x1(x1), .x2(x2), .y(y), .z1(z1), .z2(z2),
    .fb_base(fb_base), .zb_base(zb_base), .stride(stride), .hl_done(hl_done),
    .hl_start(hl_start), .dx(dx), .slope(slope), .rem(rem), .err(err), .z_start(z_start),
    .fb_addr(fb_addr), .zbuff_addr(zbuff_addr), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic model(input logic [15:0] a1, a2, yy, st, input logic [31:0] b1, b2, fb, zb,
                       output logic [31:0] e[7]);
    longint xl, xr, zl, zr, d, dzv, mag, q, r, p;
    if (a1 <= a2) begin xl = a1; xr = a2; zl = b1; zr = b2; end
    else begin xl = a2; xr = a1; zl = b2; zr = b1; end
    d   = xr - xl + 1;
    dzv = zr - zl;
    mag = dzv < 0 ? -dzv : dzv;
    q   = mag / d;
    r   = mag % d;
    p   = longint'(yy) * longint'(st) + xl;
    e[0] = 32'(d);
    e[1] = dzv < 0 ? 32'(-q) : 32'(q);
    e[2] = 32'(r);
    e[3] = 32'd0;
    e[4] = 32'(zl);
    e[5] = 32'(longint'(fb) + 4 * p);
    e[6] = 32'(longint'(zb) + 4 * p);
  endtask
  task automatic snap(output logic [31:0] s[7]);
    s[0] = dx; s[1] = slope; s[2] = rem; s[3] = err; s[4] = z_start; s[5] = fb_addr; s[6] = zbuff_addr;
  endtask
  task automatic do_span(input logic [15:0] a1, a2, yy, st, input logic [31:0] b1, b2, fb, zb,
                         output int lat, output int dn, output logic [31:0] o[7],
                         output bit stable, output logic bmid, output logic bafter, output logic dafter);
    logic [31:0] cur[7];
    @(negedge clk);
    x1 = a1; x2 = a2; y = yy; stride = st; z1 = b1; z2 = b2; fb_base = fb; zb_base = zb; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    x1 = 16'($urandom); x2 = 16'($urandom); y = 16'($urandom); stride = 16'($urandom);
    z1 = $urandom; z2 = $urandom; fb_base = $urandom; zb_base = $urandom;
    lat = 0; dn = 0; stable = 1'b0; bmid = 1'b0;
    for (int i = 0; i < 7; i++) o[i] = '0;
    for (int k = 1; k < 90 && dn == 0; k++) begin
      @(negedge clk);
      if (k == 1) bmid = busy;
      if (hl_start && lat == 0) begin lat = k + 1; snap(o); end
      if (lat != 0 && k == lat) hl_done = 1'b1;
      if (done) begin
        dn = k;
        hl_done = 1'b0;
        snap(cur);
        stable = 1'b1;
        for (int i = 0; i < 7; i++) if (cur[i] !== o[i]) stable = 1'b0;
      end
    end
    hl_done = 1'b0;
    @(negedge clk);
    bafter = busy;
    dafter = done;
  endtask
  task automatic test_reset();
    nreset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({hl_start, busy, done, dx, slope, rem, err, z_start, fb_addr, zbuff_addr} !== '0) begin
      errs++;
      $display("FAIL reset_state got=%h required=0", {hl_start, busy, done, dx, slope, rem, err, z_start, fb_addr, zbuff_addr});
    end
    nreset = 1'b1;
  endtask
  typedef struct {
    logic [15:0] a1, a2, yy, st;
    logic [31:0] b1, b2, fb, zb, edx, esl, erem, ezs, efb, ezb;
  } vec_t;
  task automatic test_directed();
    vec_t dv[4];
    int lat, dn;
    logic [31:0] o[7];
    bit stable;
    logic bm, ba, da;
    dv[0] = '{16'd0, 16'd255, 16'd0, 16'd0, 32'd1000, 32'd1512, 32'd0, 32'd0,
              32'd256, 32'd2, 32'd0, 32'd1000, 32'd0, 32'd0};
    dv[1] = '{16'd10, 16'd3, 16'd0, 16'd0, 32'd500, 32'd100, 32'd0, 32'd0,
              32'd8, 32'd50, 32'd0, 32'd100, 32'd12, 32'd12};
    dv[2] = '{16'd0, 16'd2, 16'd0, 16'd0, 32'd10, 32'd0, 32'd0, 32'd0,
              32'd3, 32'hFFFFFFFD, 32'd1, 32'd10, 32'd0, 32'd0};
    dv[3] = '{16'd5, 16'd5, 16'd2, 16'd640, 32'd7, 32'd7, 32'h10000000, 32'h20000000,
              32'd1, 32'd0, 32'd0, 32'd7, 32'h10001414, 32'h20001414};
    for (int v = 0; v < 4; v++) begin
      do_span(dv[v].a1, dv[v].a2, dv[v].yy, dv[v].st, dv[v].b1, dv[v].b2, dv[v].fb, dv[v].zb,
              lat, dn, o, stable, bm, ba, da);
      checks++; if (lat !== 35) begin errs++; $display("FAIL dir%0d latency got=%0d required=35", v, lat); end
      checks++; if (o[0] !== dv[v].edx) begin errs++; $display("FAIL dir%0d dx got=%h required=%h", v, o[0], dv[v].edx); end
      checks++; if (o[1] !== dv[v].esl) begin errs++; $display("FAIL dir%0d slope got=%h required=%h", v, o[1], dv[v].esl); end
      checks++; if (o[2] !== dv[v].erem) begin errs++; $display("FAIL dir%0d rem got=%h required=%h", v, o[2], dv[v].erem); end
      checks++; if (o[4] !== dv[v].ezs) begin errs++; $display("FAIL dir%0d z_start got=%h required=%h", v, o[4], dv[v].ezs); end
      checks++; if (o[5] !== dv[v].efb) begin errs++; $display("FAIL dir%0d fb_addr got=%h required=%h", v, o[5], dv[v].efb); end
      checks++; if (o[6] !== dv[v].ezb) begin errs++; $display("FAIL dir%0d zbuff_addr got=%h required=%h", v, o[6], dv[v].ezb); end
    end
  endtask
  task automatic test_random();
    logic [15:0] a1, a2, yy, st;
    logic [31:0] b1, b2, fb, zb;
    logic [31:0] e[7], o[7];
    int lat, dn;
    bit stable;
    logic bm, ba, da;
    for (int n = 0; n < 24; n++) begin
      a1 = 16'($urandom); yy = 16'($urandom); st = 16'($urandom);
      b1 = $urandom; fb = $urandom; zb = $urandom;
      case ($urandom_range(0, 3))
        0: a2 = a1;
        1: a2 = a1 + 16'($urandom_range(0, 20));
        default: a2 = 16'($urandom);
      endcase
      b2 = $urandom_range(0, 3) == 0 ? b1 : $urandom;
      if (n == 0) begin a1 = 16'd0; a2 = 16'hFFFF; b1 = 32'd0; b2 = 32'hFFFFFFFF; end
      if (n == 1) begin a1 = 16'hFFFF; a2 = 16'd0; b1 = 32'hFFFFFFFF; b2 = 32'd0; end
      model(a1, a2, yy, st, b1, b2, fb, zb, e);
      do_span(a1, a2, yy, st, b1, b2, fb, zb, lat, dn, o, stable, bm, ba, da);
      checks++; if (lat !== 35) begin errs++; $display("FAIL rnd%0d latency got=%0d required=35", n, lat); end
      for (int i = 0; i < 7; i++) begin
        checks++;
        if (o[i] !== e[i]) begin errs++; $display("FAIL rnd%0d %s got=%h required=%h", n, fn[i], o[i], e[i]); end
      end
      checks++; if (stable !== 1'b1) begin errs++; $display("FAIL rnd%0d outputs_stable got=%0d required=1", n, stable); end
      checks++; if (dn !== 37) begin errs++; $display("FAIL rnd%0d done_cycle got=%0d required=37", n, dn); end
      checks++; if (bm !== 1'b1) begin errs++; $display("FAIL rnd%0d busy_mid got=%b required=1", n, bm); end
      checks++; if ({ba, da} !== 2'b00) begin errs++; $display("FAIL rnd%0d busy_done_after got=%b required=00", n, {ba, da}); end
    end
  endtask
  task automatic test_hl_done();
    int lat = 0, dn = 0, extra = 0;
    @(negedge clk);
    x1 = 16'd40; x2 = 16'd20; y = 16'd9; stride = 16'd100; z1 = 32'd900; z2 = 32'd300;
    fb_base = 32'h1234; zb_base = 32'h5678; hl_done = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k < 90 && dn == 0; k++) begin
      @(negedge clk);
      if (hl_start && lat == 0) lat = k + 1;
      if (lat != 0 && k == lat + 1) hl_done = 1'b0;
      if (lat != 0 && k == lat + 3) start = 1'b1;
      if (lat != 0 && k == lat + 4) start = 1'b0;
      if (lat != 0 && k == lat + 8) hl_done = 1'b1;
      if (done) dn = k;
    end
    hl_done = 1'b0;
    start = 1'b0;
    checks++; if (lat !== 35) begin errs++; $display("FAIL hl_done_latency got=%0d required=35", lat); end
    checks++; if (dn !== 44) begin errs++; $display("FAIL hl_done_done_cycle got=%0d required=44", dn); end
    repeat (45) begin @(negedge clk); if (hl_start || done) extra++; end
    checks++; if (extra !== 0) begin errs++; $display("FAIL start_in_wait_ignored got=%0d required=0", extra); end
  endtask
  task automatic test_reset_mid_div();
    int extra = 0, lat, dn;
    logic [31:0] e[7], o[7];
    bit stable;
    logic bm, ba, da;
    @(negedge clk);
    x1 = 16'd7; x2 = 16'd300; y = 16'd3; stride = 16'd50; z1 = 32'd5; z2 = 32'd99999;
    fb_base = 32'hAA00; zb_base = 32'hBB00; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    nreset = 1'b0;
    @(negedge clk);
    checks++;
    if ({hl_start, busy, done, dx, slope, rem, err, z_start, fb_addr, zbuff_addr} !== '0) begin
      errs++;
      $display("FAIL mid_div_reset got=%h required=0", {hl_start, busy, done, dx, slope, rem, err, z_start, fb_addr, zbuff_addr});
    end
    nreset = 1'b1;
    repeat (45) begin @(negedge clk); if (hl_start || done) extra++; end
    checks++; if (extra !== 0) begin errs++; $display("FAIL abandoned_span_pulses got=%0d required=0", extra); end
    model(16'd7, 16'd300, 16'd3, 16'd50, 32'd5, 32'd99999, 32'hAA00, 32'hBB00, e);
    do_span(16'd7, 16'd300, 16'd3, 16'd50, 32'd5, 32'd99999, 32'hAA00, 32'hBB00, lat, dn, o, stable, bm, ba, da);
    checks++; if (lat !== 35) begin errs++; $display("FAIL post_reset_latency got=%0d required=35", lat); end
    checks++; if (o[1] !== e[1]) begin errs++; $display("FAIL post_reset_slope got=%h required=%h", o[1], e[1]); end
    checks++; if (o[5] !== e[5]) begin errs++; $display("FAIL post_reset_fb_addr got=%h required=%h", o[5], e[5]); end
    checks++; if (dn !== 37) begin errs++; $display("FAIL post_reset_done_cycle got=%0d required=37", dn); end
  endtask
  initial begin
    start = 1'b0; hl_done = 1'b0; nreset = 1'b0;
    x1 = '0; x2 = '0; y = '0; stride = '0; z1 = '0; z2 = '0; fb_base = '0; zb_base = '0;
    test_reset();
    test_directed();
    test_random();
    test_hl_done();
    test_reset_mid_div();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/hline_setup.md
HLINE_SETUP -- requirements
Module: hline_setup

Interface
REQ-001 clk  input  1  clock; all state changes on rising edge.
REQ-002 nreset  input  1  reset, synchronous, active-low.
REQ-003 start  input  1  request; sampled only in IDLE.
REQ-004 x1, x2  input  16 each  span endpoints, unsigned pixel columns, either order.
REQ-005 y  input  16  span row, unsigned.
REQ-006 z1, z2  input  32 each  depth at x1 / x2, unsigned.
REQ-007 fb_base, zb_base  input  32 each  byte base addresses of frame buffer and z-buffer.
REQ-008 stride  input  16  pixels per row.
REQ-009 hl_done  input  1  level done from the downstream span fill stage.
REQ-010 hl_start  output  1  one-cycle launch pulse to the span fill stage.
REQ-011 dx  output  32  pixel count, zero-extended.
REQ-012 slope, rem, err, z_start  output  32 each  z-interpolation terms for the span fill stage.
REQ-013 fb_addr, zbuff_addr  output  32 each  byte address of leftmost pixel.
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 done  output  1  one-cycle pulse when the span is fully written.

Function
REQ-016 States: IDLE, ORDER, DIV, ADDR, ISSUE, WAIT, DONE, held in a 3-bit register.
REQ-017 IDLE: start=1 -> latch all inputs, go ORDER; start while busy is ignored.
REQ-018 ORDER (1 cycle): if x1>x2 swap x and z pairs; xl=min, xr=max; dx=xr-xl+1 (17-bit, range 1..65536); dz=zr-zl as 33-bit signed; store |dz| and sign; z_start=zl.
REQ-019 DIV (exactly 32 cycles): restoring divide |dz| / dx, one quotient bit per cycle, MSB first; quotient q, remainder r.
REQ-020 ADDR (1 cycle): slope=sign?-q:q (two's complement, truncated to 32 bits); rem=r; err=0.
REQ-021 ADDR: pix=y*stride+xl (32-bit, wraps); fb_addr=fb_base+(pix<<2); zbuff_addr=zb_base+(pix<<2); both mod 2^32.
REQ-022 ISSUE (1 cycle): hl_start=1, go WAIT.
REQ-023 WAIT: hl_done ignored in the first WAIT cycle; from the second cycle onward hl_done=1 -> DONE.
REQ-024 DONE (1 cycle): done=1, go IDLE.
REQ-025 Latency: start sampled at cycle N -> hl_start high at cycle N+35.
REQ-026 dx, slope, rem, err, z_start, fb_addr, zbuff_addr are registered, stable from ISSUE through DONE, and unchanged in IDLE until the next ADDR.
REQ-027 x1==x2: dx=1, slope=dz, rem=0; no special path.
REQ-028 dz=0: slope=0, rem=0.
REQ-029 Input changes after the start cycle have no effect on the current span.

Reset
REQ-030 nreset=0 at any clock edge: state=IDLE; all outputs and internal registers = 0; hl_start, busy, and done = 0 the following cycle.
REQ-031 Reset mid-DIV or mid-WAIT: abandon the span silently; no hl_start or done is issued for it.

Verification
REQ-032 x1=0, x2=255, z1=1000, z2=1512, start -> hl_start at N+35; dx=256, slope=2, rem=0, z_start=1000.
REQ-033 x1=10, x2=3, z1=500, z2=100 -> swap; dx=8, z_start=100, slope=50, rem=0.
REQ-034 x1=0, x2=2, z1=10, z2=0 -> dx=3, slope=-3 (0xFFFFFFFD), rem=1.
REQ-035 fb_base=0x10000000, zb_base=0x20000000, y=2, stride=640, x1=x2=5 -> fb_addr=0x10001414, zbuff_addr=0x20001414, dx=1.
REQ-036 hl_done held high from the previous span, start pulse -> no done until hl_done drops and rises again after the first WAIT cycle; start during WAIT is ignored.
REQ-037 nreset low during DIV cycle 10 -> IDLE next cycle, all outputs 0, no hl_start; a new start then completes normally.
